dnoc_itf_in_d_channel: RTL and testbench

- NoC-side receive interface of a node's data channel.
- Accepts packets ejected by the local router (head flit plus body flits ending with last) and decodes the head flit.
- Steers body flits to one of three sinks:
  - local scratchpad write port, with a 4-level loop address generator;
  - core read-return port;
  - DMA write-return port.
- Counterpart of the node's outbound d-channel packetiser; it consumes the head-flit format that block produces.

---
 rtl/dnoc_pkg.sv | 29 ++
 rtl/dnoc_loop_addr_gen.sv | 92 +++++++++
 rtl/dnoc_itf_in_d_channel.sv | 169 ++++++++++++++++
 tb/tb_dnoc_itf_in_d_channel.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnoc_pkg.sv
// Shared definitions for the node d-channel: head-flit field layout and FSM states.
// Used by both the inbound interface and the outbound packetiser.
package dnoc_pkg;

  localparam int FLIT_W       = 256;
  localparam int LOOP_W       = 13;
  localparam int LOOP_LVLS    = 4;

  localparam int TYPE_BIT     = 12;   // 1 = return packet, 0 = write packet
  localparam int SRC_SEL_BIT  = 13;   // return: 0 core / 1 dma; write: issued by dma
  localparam int SRC_ID_LSB   = 14;
  localparam int SRC_ID_W     = 4;
  localparam int ADDR_LSB     = 18;
  localparam int LEN_LSB      = 43;
  localparam int LOOP_GAP_LSB = 56;
  localparam int LOOP_LEN_LSB = 108;
  localparam int SYNC_TGT_LSB = 160;
  localparam int SYNC_TGT_W   = 12;

  localparam logic [SRC_ID_W-1:0] DMA_ID = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RTN_C = 2'd2,
    ST_RTN_D = 2'd3
  } d_state_e;

endpackage

// File: rtl/dnoc_loop_addr_gen.sv
// Four-level nested loop address generator: innermost level steps by gap[0],
// each wrap of level i-1 advances that level's start by gap[i] and reloads addr.
module dnoc_loop_addr_gen #(
  parameter int ADDR_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [ADDR_W-1:0]       base,
  input  logic [3:0][ADDR_W-1:0]  len,
  input  logic [3:0][ADDR_W-1:0]  gap,
  input  logic                    step,
  output logic [ADDR_W-1:0]       addr
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [3:0][ADDR_W-1:0] len_q;
  logic [3:0][ADDR_W-1:0] gap_q;
  logic [3:0][ADDR_W-1:0] cnt_q;
  logic [3:0][ADDR_W-1:0] lim;
  logic [ADDR_W-1:0]      base_q;
  logic [ADDR_W-1:0]      s1_q;
  logic [ADDR_W-1:0]      s2_q;
  logic [ADDR_W-1:0]      s3_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [3:0]             wrap;

  // A loop length of zero behaves as a single-iteration loop.
  always_comb begin
    lim  = '0;
    wrap = '0;
    for (int i = 0; i < 4; i++) begin
      lim[i]  = (len_q[i] == '0) ? ONE : len_q[i];
      wrap[i] = ((cnt_q[i] + ONE) == lim[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      gap_q  <= '0;
      cnt_q  <= '0;
      base_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      addr_q <= '0;
    end else if (load) begin
      len_q  <= len;
      gap_q  <= gap;
      cnt_q  <= '0;
      base_q <= base;
      s1_q   <= base;
      s2_q   <= base;
      s3_q   <= base;
      addr_q <= base;
    end else if (step) begin
      if (!wrap[0]) begin
        cnt_q[0] <= cnt_q[0] + ONE;
        addr_q   <= addr_q + gap_q[0];
      end else if (!wrap[1]) begin
        cnt_q[0] <= '0;
        cnt_q[1] <= cnt_q[1] + ONE;
        s1_q     <= s1_q + gap_q[1];
        addr_q   <= s1_q + gap_q[1];
      end else if (!wrap[2]) begin
        cnt_q[1:0] <= '0;
        cnt_q[2]   <= cnt_q[2] + ONE;
        s2_q       <= s2_q + gap_q[2];
        s1_q       <= s2_q + gap_q[2];
        addr_q     <= s2_q + gap_q[2];
      end else if (!wrap[3]) begin
        cnt_q[2:0] <= '0;
        cnt_q[3]   <= cnt_q[3] + ONE;
        s3_q       <= s3_q + gap_q[3];
        s2_q       <= s3_q + gap_q[3];
        s1_q       <= s3_q + gap_q[3];
        addr_q     <= s3_q + gap_q[3];
      end else begin
        cnt_q  <= '0;
        s1_q   <= base_q;
        s2_q   <= base_q;
        s3_q   <= base_q;
        addr_q <= base_q;
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/dnoc_itf_in_d_channel.sv
// Inbound d-channel interface: decodes the head flit and steers body flits to the
// scratchpad write port, the core return port or the DMA return port, unbuffered.
module dnoc_itf_in_d_channel
  import dnoc_pkg::*;
#(
  parameter logic [3:0] NODE_ID = 4'd0,
  parameter int         ADDR_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_W-1:0]     out_flit,
  input  logic                  out_last,
  input  logic                  out_valid,
  output logic                  out_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [FLIT_W-1:0]     wr_data,
  output logic                  wr_valid,
  output logic                  wr_last,
  input  logic                  wr_ready,
  output logic [FLIT_W-1:0]     core_rtn_data,
  output logic                  core_rtn_valid,
  output logic                  core_rtn_last,
  input  logic                  core_rtn_ready,
  output logic [FLIT_W-1:0]     dma_rtn_data,
  output logic                  dma_rtn_valid,
  output logic                  dma_rtn_last,
  input  logic                  dma_rtn_ready,
  output logic [SRC_ID_W-1:0]   pkt_src_id,
  output logic                  pkt_from_dma,
  output logic [SYNC_TGT_W-1:0] rtn_sync_target,
  output logic                  pkt_done,
  output logic                  len_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Handshake rule on every port: a beat transfers on the clock edge where valid
  // and ready are both high; valid is never withdrawn before that edge.

  d_state_e               state_q;
  logic [ADDR_W-1:0]      len_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [SRC_ID_W-1:0]    src_id_q;
  logic                   from_dma_q;
  logic [SYNC_TGT_W-1:0]  sync_q;
  logic                   done_q;

  logic [3:0][ADDR_W-1:0] head_len;
  logic [3:0][ADDR_W-1:0] head_gap;
  logic [ADDR_W-1:0]      gen_addr;
  logic                   gen_load;
  logic                   gen_step;
  logic                   in_range;
  logic                   hs;
  logic                   unused_node_id;

  assign unused_node_id = ^NODE_ID;

  always_comb begin
    head_len = '0;
    head_gap = '0;
    for (int i = 0; i < LOOP_LVLS; i++) begin
      head_len[i] = out_flit[LOOP_LEN_LSB + i*LOOP_W +: ADDR_W];
      head_gap[i] = out_flit[LOOP_GAP_LSB + i*LOOP_W +: ADDR_W];
    end
  end

  // Beats past the declared length are swallowed without reaching the scratchpad.
  assign in_range = ({1'b0, len_q} > beat_cnt_q);
  assign hs       = out_valid & out_ready;
  assign gen_load = (state_q == ST_IDLE) & out_valid & ~out_flit[TYPE_BIT];
  assign gen_step = (state_q == ST_WR) & hs & in_range;

  always_comb begin
    out_ready      = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    wr_valid       = 1'b0;
    wr_last        = 1'b0;
    core_rtn_data  = '0;
    core_rtn_valid = 1'b0;
    core_rtn_last  = 1'b0;
    dma_rtn_data   = '0;
    dma_rtn_valid  = 1'b0;
    dma_rtn_last   = 1'b0;
    len_err        = 1'b0;
    case (state_q)
      ST_IDLE: out_ready = 1'b1;
      ST_WR: begin
        out_ready = in_range ? wr_ready : 1'b1;
        wr_addr   = gen_addr;
        wr_data   = out_flit;
        wr_valid  = out_valid & in_range;
        wr_last   = out_valid & out_last & in_range;
        len_err   = out_valid & out_ready & out_last &
                    ((beat_cnt_q + CNT_ONE) != {1'b0, len_q});
      end
      ST_RTN_C: begin
        out_ready      = core_rtn_ready;
        core_rtn_data  = out_flit;
        core_rtn_valid = out_valid;
        core_rtn_last  = out_valid & out_last;
      end
      default: begin
        out_ready     = dma_rtn_ready;
        dma_rtn_data  = out_flit;
        dma_rtn_valid = out_valid;
        dma_rtn_last  = out_valid & out_last;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      src_id_q   <= '0;
      from_dma_q <= 1'b0;
      sync_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= hs & out_last;
      case (state_q)
        ST_IDLE: begin
          if (out_valid) begin
            src_id_q   <= out_flit[SRC_ID_LSB +: SRC_ID_W];
            beat_cnt_q <= '0;
            if (out_flit[TYPE_BIT]) begin
              sync_q <= out_flit[SYNC_TGT_LSB +: SYNC_TGT_W];
              if (!out_last) state_q <= out_flit[SRC_SEL_BIT] ? ST_RTN_D : ST_RTN_C;
            end else begin
              from_dma_q <= out_flit[SRC_SEL_BIT];
              len_q      <= out_flit[LEN_LSB +: ADDR_W];
              if (!out_last) state_q <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (hs) begin
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_ONE;
            if (out_last) state_q <= ST_IDLE;
          end
        end
        default: begin
          if (hs && out_last) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  dnoc_loop_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gen_load),
    .base  (out_flit[ADDR_LSB +: ADDR_W]),
    .len   (head_len),
    .gap   (head_gap),
    .step  (gen_step),
    .addr  (gen_addr)
  );

  assign pkt_src_id      = src_id_q;
  assign pkt_from_dma    = from_dma_q;
  assign rtn_sync_target = sync_q;
  assign pkt_done        = done_q;

endmodule

// File: tb/tb_dnoc_itf_in_d_channel.sv
// Bench for dnoc_itf_in_d_channel: per-flit expectation queue built from packet
// contents, nested-loop address model, directed cases followed by random traffic.
module tb_dnoc_itf_in_d_channel;
  import dnoc_pkg::*;

  localparam int AW = 13;

  typedef enum logic [2:0] {K_HEAD, K_WR, K_DISC, K_CORE, K_DMA} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic        err;
    logic        last;
    logic [AW-1:0] addr;
    logic [255:0] data;
    logic [3:0]  src;
    logic        from_dma;
    logic [11:0] sync;
  } beat_t;

  logic clk, rst_n;
  logic [255:0] out_flit;
  logic out_last, out_valid, out_ready;
  logic [AW-1:0] wr_addr;
  logic [255:0] wr_data, core_rtn_data, dma_rtn_data;
  logic wr_valid, wr_last, wr_ready;
  logic core_rtn_valid, core_rtn_last, core_rtn_ready;
  logic dma_rtn_valid, dma_rtn_last, dma_rtn_ready;
  logic [3:0] pkt_src_id;
  logic pkt_from_dma;
  logic [11:0] rtn_sync_target;
  logic pkt_done, len_err;

  beat_t exp_q[$];
  logic  pat_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    core_beats = 0;
  int    dma_beats = 0;
  int    len_errs = 0;
  logic  done_pending = 1'b0;
  bit    mon_en = 0;
  bit    rand_ready = 0;
  bit    gap_en = 0;
  logic [3:0]  m_src = '0;
  logic        m_dma = 1'b0;
  logic [11:0] m_sync = '0;

  dnoc_itf_in_d_channel #(.NODE_ID(4'd0), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .core_rtn_data(core_rtn_data), .core_rtn_valid(core_rtn_valid), .core_rtn_last(core_rtn_last),
    .core_rtn_ready(core_rtn_ready),
    .dma_rtn_data(dma_rtn_data), .dma_rtn_valid(dma_rtn_valid), .dma_rtn_last(dma_rtn_last),
    .dma_rtn_ready(dma_rtn_ready),
    .pkt_src_id(pkt_src_id), .pkt_from_dma(pkt_from_dma), .rtn_sync_target(rtn_sync_target),
    .pkt_done(pkt_done), .len_err(len_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address of beat j: mixed-radix decomposition of j over the loop lengths.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base,
                                               input logic [3:0][AW-1:0] lens,
                                               input logic [3:0][AW-1:0] gaps,
                                               input int j);
    longint sum;
    int idx, l;
    sum = longint'(base);
    idx = j;
    for (int i = 0; i < 4; i++) begin
      l   = (lens[i] == 0) ? 1 : int'(lens[i]);
      sum = sum + longint'(idx % l) * longint'(gaps[i]);
      idx = idx / l;
    end
    return sum[AW-1:0];
  endfunction

  function automatic logic [255:0] rand_flit();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic send_flit(input logic [255:0] d, input logic l);
    int n;
    out_flit = d; out_last = l; out_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_ready) break;
      n++;
      if (n > 200) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: no out_ready within 200 cycles at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    out_valid = 1'b0; out_last = 1'b0; out_flit = '0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_wr_pkt(input logic [3:0] src, input logic dma, input logic [AW-1:0] base,
                             input logic [3:0][AW-1:0] lens, input logic [3:0][AW-1:0] gaps,
                             input logic [AW-1:0] len, input int nbeats, input int nsend);
    logic [255:0] head, d;
    beat_t e;
    head = rand_flit();
    head[12] = 1'b0;
    head[13] = dma;
    head[17:14] = src;
    head[30:18] = base;
    head[55:43] = len;
    for (int i = 0; i < 4; i++) begin
      head[56 + 13*i +: 13]  = gaps[i];
      head[108 + 13*i +: 13] = lens[i];
    end
    m_src = src; m_dma = dma;
    e = '0; e.kind = K_HEAD; e.last = (nbeats == 0);
    exp_q.push_back(e);
    send_flit(head, nbeats == 0);
    for (int k = 1; k <= nsend; k++) begin
      d = rand_flit();
      e = '0;
      e.kind = (k <= int'(len)) ? K_WR : K_DISC;
      e.last = (k == nbeats);
      e.err  = (k == nbeats) && (k != int'(len));
      e.addr = model_addr(base, lens, gaps, k - 1);
      e.data = d; e.src = m_src; e.from_dma = m_dma; e.sync = m_sync;
      exp_q.push_back(e);
      send_flit(d, k == nbeats);
    end
  endtask

  task automatic send_rtn_pkt(input logic [3:0] src, input logic to_dma, input logic [11:0] sync,
                              input int nbeats);
    logic [255:0] head, d;
    beat_t e;
    head = rand_flit();
    head[12] = 1'b1;
    head[13] = to_dma;
    head[17:14] = src;
    head[171:160] = sync;
    m_src = src; m_sync = sync;
    e = '0; e.kind = K_HEAD; e.last = (nbeats == 0);
    exp_q.push_back(e);
    send_flit(head, nbeats == 0);
    for (int k = 1; k <= nbeats; k++) begin
      d = rand_flit();
      e = '0;
      e.kind = to_dma ? K_DMA : K_CORE;
      e.last = (k == nbeats);
      e.data = d; e.src = m_src; e.from_dma = m_dma; e.sync = m_sync;
      exp_q.push_back(e);
      send_flit(d, k == nbeats);
    end
  endtask

  // ---------------- sink ready driver ----------------
  initial begin
    wr_ready = 1'b1; core_rtn_ready = 1'b1; dma_rtn_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (pat_q.size() > 0) begin
        wr_ready = pat_q.pop_front();
      end else if (rand_ready) begin
        wr_ready       = ($urandom_range(0, 3) != 0);
        core_rtn_ready = ($urandom_range(0, 3) != 0);
        dma_rtn_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        wr_ready = 1'b1; core_rtn_ready = 1'b1; dma_rtn_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    beat_t e;
    logic  er;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) continue;
      check("pkt_done", pkt_done, done_pending);
      done_pending = 1'b0;
      if (len_err) len_errs++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL exp_q_empty: flit offered with no expectation at %0t", $time);
        end else begin
          e = exp_q[0];
          case (e.kind)
            K_WR:    er = wr_ready;
            K_CORE:  er = core_rtn_ready;
            K_DMA:   er = dma_rtn_ready;
            default: er = 1'b1;
          endcase
          check("out_ready", out_ready, er);
          check("wr_valid", wr_valid, e.kind == K_WR);
          check("core_rtn_valid", core_rtn_valid, e.kind == K_CORE);
          check("dma_rtn_valid", dma_rtn_valid, e.kind == K_DMA);
          check("wr_last", wr_last, (e.kind == K_WR) && e.last);
          check("core_rtn_last", core_rtn_last, (e.kind == K_CORE) && e.last);
          check("dma_rtn_last", dma_rtn_last, (e.kind == K_DMA) && e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            check("len_err", len_err, e.err);
            done_pending = e.last;
            if (e.kind == K_WR) begin
              check("wr_addr", wr_addr, e.addr);
              check("wr_data", wr_data, e.data);
            end
            if (e.kind == K_CORE) begin
              core_beats++;
              check("core_rtn_data", core_rtn_data, e.data);
            end
            if (e.kind == K_DMA) begin
              dma_beats++;
              check("dma_rtn_data", dma_rtn_data, e.data);
            end
            if (e.kind != K_HEAD) begin
              check("pkt_src_id", pkt_src_id, e.src);
              check("pkt_from_dma", pkt_from_dma, e.from_dma);
              check("rtn_sync_target", rtn_sync_target, e.sync);
            end
          end else begin
            check("len_err_idle", len_err, 1'b0);
          end
        end
      end else begin
        check("wr_valid_idle", wr_valid, 1'b0);
        check("core_valid_idle", core_rtn_valid, 1'b0);
        check("dma_valid_idle", dma_rtn_valid, 1'b0);
        check("len_err_idle", len_err, 1'b0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_ready"}, out_ready, 1'b1);
    check({tag, "_wr_valid"}, wr_valid, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, '0);
    check({tag, "_wr_last"}, wr_last, 1'b0);
    check({tag, "_rtn_valids"}, {core_rtn_valid, dma_rtn_valid}, 2'b00);
    check({tag, "_pkt_done"}, pkt_done, 1'b0);
    check({tag, "_len_err"}, len_err, 1'b0);
    check({tag, "_pkt_src_id"}, pkt_src_id, 4'h0);
    check({tag, "_pkt_from_dma"}, pkt_from_dma, 1'b0);
    check({tag, "_rtn_sync_target"}, rtn_sync_target, 12'h000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0][AW-1:0] lens, gaps;
    logic [AW-1:0] a;
    int c0, d0, e0, nb, ln, seen;
    rst_n = 1'b0; out_flit = '0; out_last = 1'b0; out_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;

    // pin the address model against hand-computed sequences
    lens = '0; gaps = '0; lens[0] = 13'd4; gaps[0] = 13'd1;
    for (int j = 0; j < 4; j++) begin
      a = model_addr(13'h100, lens, gaps, j);
      check("model_linear", a, 13'h100 + 13'(j));
    end
    lens = '0; gaps = '0; lens[0] = 13'd3; lens[1] = 13'd2; gaps[0] = 13'd1; gaps[1] = 13'd16;
    for (int j = 0; j < 6; j++) begin
      a = model_addr(13'h000, lens, gaps, j);
      check("model_2d", a, (j < 3) ? 13'(j) : 13'(16 + j - 3));
    end
    lens = '0; gaps = '0; lens[0] = 13'd4; gaps[0] = 13'd1;
    a = model_addr(13'h1FFE, lens, gaps, 2);
    check("model_wrap2", a, 13'h0000);
    a = model_addr(13'h1FFE, lens, gaps, 3);
    check("model_wrap3", a, 13'h0001);

    // return to core with sync target 0x0A5
    c0 = core_beats; d0 = dma_beats;
    send_rtn_pkt(4'h3, 1'b0, 12'h0A5, 3);
    repeat (2) @(posedge clk); #1;
    check("core_beat_count", core_beats - c0, 3);
    check("dma_beat_count", dma_beats - d0, 0);
    check("sync_literal", rtn_sync_target, 12'h0A5);

    // linear write, then again with wr_ready toggling 1,0,0,1
    lens = '0; gaps = '0; lens[0] = 13'd4; gaps[0] = 13'd1;
    e0 = len_errs;
    send_wr_pkt(4'h5, 1'b0, 13'h100, lens, gaps, 13'd4, 4, 4);
    pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b0); pat_q.push_back(1'b1);
    pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b1);
    send_wr_pkt(4'h6, 1'b1, 13'h100, lens, gaps, 13'd4, 4, 4);
    repeat (2) @(posedge clk); #1;
    check("linear_len_err_count", len_errs - e0, 0);

    // 2-D write
    lens = '0; gaps = '0; lens[0] = 13'd3; lens[1] = 13'd2; gaps[0] = 13'd1; gaps[1] = 13'd16;
    send_wr_pkt(4'h7, 1'b0, 13'h000, lens, gaps, 13'd6, 6, 6);

    // length mismatches: long packet and short packet
    lens = '0; gaps = '0; lens[0] = 13'd4; gaps[0] = 13'd1;
    e0 = len_errs;
    send_wr_pkt(4'h8, 1'b0, 13'h040, lens, gaps, 13'd2, 4, 4);
    repeat (2) @(posedge clk); #1;
    check("long_len_err_count", len_errs - e0, 1);
    e0 = len_errs;
    send_wr_pkt(4'h9, 1'b0, 13'h080, lens, gaps, 13'd4, 2, 2);
    repeat (2) @(posedge clk); #1;
    check("short_len_err_count", len_errs - e0, 1);

    // address wrap, then reset in the middle of the same kind of packet
    send_wr_pkt(4'hA, 1'b0, 13'h1FFE, lens, gaps, 13'd4, 4, 4);
    send_wr_pkt(4'hB, 1'b1, 13'h1FFE, lens, gaps, 13'd4, 4, 2);
    mon_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midpkt");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    done_pending = 1'b0;
    m_src = '0; m_dma = 1'b0; m_sync = '0;
    mon_en = 1;

    // random traffic
    rand_ready = 1; gap_en = 1;
    for (int p = 0; p < 150; p++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < 4; i++) begin
            lens[i] = 13'($urandom_range(0, 3));
            gaps[i] = 13'($urandom_range(0, 8191));
          end
          ln = $urandom_range(0, 6);
          nb = ($urandom_range(0, 1) == 1) ? ln : $urandom_range(0, 8);
          send_wr_pkt(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      13'($urandom_range(0, 8191)), lens, gaps, 13'(ln), nb, nb);
        end
        1: send_rtn_pkt(4'($urandom_range(0, 15)), 1'b0, 12'($urandom_range(0, 4095)),
                        $urandom_range(0, 5));
        default: send_rtn_pkt(4'($urandom_range(0, 15)), 1'b1, 12'($urandom_range(0, 4095)),
                              $urandom_range(0, 5));
      endcase
    end
    repeat (3) @(posedge clk); #1;
    seen = exp_q.size();
    check("exp_q_drained", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
